// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, default memory depth.
package lsu_pkg;

    localparam int unsigned MEM_AW_DEFAULT = 8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2,
        StDone = 2'd3
    } lsu_state_e;

    // Size 3 is reserved and always reported as an error.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_ops.sv
// Little-endian lane handling: load extraction with sign/zero extension and sub-word store merge.
module lsu_lane_ops
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [31:0] st_new,
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    output logic [31:0] st_merged
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = ld_word[{ld_off, 3'b000} +: 8];
        ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    // Word stores pass straight through; sub-word stores keep the untouched lanes.
    always_comb begin
        st_merged = st_old;
        case (st_size)
            SZ_BYTE: st_merged[{st_off, 3'b000} +: 8]     = st_new[7:0];
            SZ_HALF: st_merged[{st_off[1], 4'b0000} +: 16] = st_new[15:0];
            default: st_merged = st_new;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit for a single-port word memory; sub-word stores are read-modify-write.
// Optional LSU_BOUNDS_CHECK_EN flags any address beyond the memory as an error.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_AW = MEM_AW_DEFAULT,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    lsu_state_e        state_q, state_d;
    logic [MEM_AW+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              signed_q, signed_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    logic              accept;
    logic              req_err;
    logic [31:0]       ld_data;
    logic [31:0]       st_merged;

    assign accept = req_valid && (state_q == StIdle);

`ifdef LSU_BOUNDS_CHECK_EN
    always_comb begin
        req_err = lsu_misaligned(req_size, req_addr[1:0]);
        if (req_addr[31:MEM_AW+2] != '0) begin
            req_err = 1'b1;
        end
    end
`else
    // Upper address bits are dropped so the index wraps around the memory.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];
    assign req_err = lsu_misaligned(req_size, req_addr[1:0]);
`endif

    lsu_lane_ops u_lane_ops (
        .ld_word   (mem_rd),
        .ld_off    (addr_q[1:0]),
        .ld_size   (size_q),
        .ld_signed (signed_q),
        .ld_data   (ld_data),
        .st_old    (rd_q),
        .st_new    (wdata_q),
        .st_off    (addr_q[1:0]),
        .st_size   (size_q),
        .st_merged (st_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            size_q   <= SZ_BYTE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = StDone;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = we_q ? StWr : StDone;
            StWr:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        size_d   = size_q;
        we_d     = we_q;
        signed_d = signed_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        if (accept) begin
            addr_d   = req_addr[MEM_AW+1:0];
            size_d   = req_size;
            we_d     = req_we;
            signed_d = req_signed;
            err_d    = req_err;
            wdata_d  = req_wdata;
        end
        // Stores keep the raw word for merging; loads keep the finished value.
        if (state_q == StRd) begin
            rd_d = we_q ? mem_rd : ld_data;
        end
    end

    always_comb begin
        req_ready = (state_q == StIdle) && !reset;
        rsp_valid = (state_q == StDone) && !reset;
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !we_q && !err_q) ? rd_q : '0;
        mem_a     = {{(32 - MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
        mem_we    = (state_q == StWr) && !reset;
        mem_wd    = (state_q == StWr) ? st_merged : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed vector table, reset-during-write sequence, random vs. reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_AW(8), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    // Memory model with a backdoor port used only while the unit is idle.
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_a;
    logic [31:0] bd_d;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:0]] <= mem_wd;
        else if (bd_we) mem[bd_a] <= bd_d;
    end
    assign mem_rd = mem[mem_a[7:0]];

    int          checks = 0;
    int          failures = 0;
    int          we_count = 0;
    logic [31:0] we_a = '0;
    logic [31:0] we_d = '0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_count = we_count + 1;
            we_a = mem_a;
            we_d = mem_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bd_we = 1'b1;
            bd_a  = i[7:0];
            bd_d  = ref_mem[i];
        end
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issues one request, returns the response and the cycle (after acceptance) it arrived in.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic after_v);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", {31'd0, req_ready}, 32'd1);
        we_count   = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                lat   = c;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
        end
        @(negedge clk);
        after_v = rsp_valid;
    endtask

    // Reference behaviour from the access rules, using masks and shifts on whole words.
    function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] e_rdata, output logic e_err,
                                  output int e_lat, output int e_wr,
                                  output logic [31:0] e_wa, output logic [31:0] e_wd);
        int unsigned idx;
        int unsigned sh;
        logic [31:0] mask;
        logic [31:0] raw;
        e_rdata = '0;
        e_wr    = 0;
        e_wa    = '0;
        e_wd    = '0;
        e_err   = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                  (size == 2'd2 && addr[1:0] != 2'd0);
`ifdef LSU_BOUNDS_CHECK_EN
        if ((addr >> 10) != 0) e_err = 1'b1;
`endif
        if (e_err) begin
            e_lat = 1;
            return;
        end
        idx  = (addr >> 2) % 256;
        sh   = (addr % 4) * 8;
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!we) begin
            raw = (ref_mem[idx] >> sh) & mask;
            if (sgn && size != 2'd2 && raw > (mask >> 1)) raw = raw | ~mask;
            e_rdata = raw;
            e_lat   = 2;
        end else begin
            e_wd = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
            e_wr = 1;
            e_wa = idx;
            e_lat = (size == 2'd2) ? 2 : 3;
            ref_mem[idx] = e_wd;
        end
    endfunction

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        after_v;
        int          rv;
        int          bad;
        logic [31:0] r;
        logic [31:0] r2;
        logic [1:0]  lane;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          e_wr;
        logic [31:0] e_wa;
        logic [31:0] e_wd;

        // {we, size, signed, addr, wdata, rdata, err, latency, writes, write idx, write data}
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0, 2, 0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000_8899, 1'b0, 2, 0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h13, 32'h5C, 32'h0, 1'b0, 3, 1, 32'h4, 32'h5C99_AABB});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h5C99_AABB, 1'b0, 2, 0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1C, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 32'h7,
                         32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
`ifdef LSU_BOUNDS_CHECK_EN
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
`else
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0123_4567, 1'b0, 2, 0, 32'h0, 32'h0});
`endif
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000_5C99, 1'b0, 2, 0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'hFFFF_FFBB, 1'b0, 2, 0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0000_005C, 1'b0, 2, 0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h1E, 32'hFFFF_1234, 32'h0, 1'b0, 3, 1, 32'h7,
                         32'h1234_BEEF});

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        bd_we      = 1'b0;
        bd_a       = '0;
        bd_d       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst.mem_a", mem_a, 32'd0);
        check("rst.mem_wd", mem_wd, 32'd0);
        check("rst.mem_we", {31'd0, mem_we}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ref_mem[0] = 32'h0123_4567;
        ref_mem[4] = 32'h8899_AABB;
        load_mem();

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   rdata, err, lat, after_v);
            check($sformatf("v%0d.rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d.err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d.latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d.pulse_end", i), {31'd0, after_v}, 32'd0);
            check($sformatf("v%0d.writes", i), we_count, vecs[i].exp_we);
            if (vecs[i].exp_we == 1) begin
                check($sformatf("v%0d.wr_idx", i), we_a, vecs[i].exp_wa);
                check($sformatf("v%0d.wr_data", i), we_d, vecs[i].exp_wd);
            end
        end

        // Reset lands on the write cycle of a half store to word 7.
        we_count   = 0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'd1;
        req_signed = 1'b0;
        req_addr   = 32'h1C;
        req_wdata  = 32'h0000_AAAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rstwr.in_wr", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        rv = 0;
        @(negedge clk);
        check("rstwr.we_gated", {31'd0, mem_we}, 32'd0);
        if (rsp_valid === 1'b1) rv++;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rstwr.req_ready", {31'd0, req_ready}, 32'd1);
        check("rstwr.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) rv++;
        end
        check("rstwr.no_rsp", rv, 0);
        check("rstwr.no_write", we_count, 0);
        check("rstwr.word7", mem[7], 32'h1234_BEEF);

        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        load_mem();

        for (int i = 0; i < 300; i++) begin
            r  = $urandom;
            r2 = $urandom;
            sz = r[2:1];
            lane = r[11:10];
            if (r[14:12] != 3'd0) begin
                if (sz == 2'd1) lane[0] = 1'b0;
                if (sz == 2'd2) lane = 2'd0;
            end
            addr = {22'd0, r[9:2], lane};
            if (r[17:15] == 3'd0) addr[31:10] = r2[21:0] | 22'd1;
            model(r[0], sz, r[3], addr, r2, e_rdata, e_err, e_lat, e_wr, e_wa, e_wd);
            do_req(r[0], sz, r[3], addr, r2, rdata, err, lat, after_v);
            check($sformatf("r%0d.rdata", i), rdata, e_rdata);
            check($sformatf("r%0d.err", i), {31'd0, err}, {31'd0, e_err});
            check($sformatf("r%0d.latency", i), lat, e_lat);
            check($sformatf("r%0d.pulse_end", i), {31'd0, after_v}, 32'd0);
            check($sformatf("r%0d.writes", i), we_count, e_wr);
            if (e_wr == 1) begin
                check($sformatf("r%0d.wr_idx", i), we_a, e_wa);
                check($sformatf("r%0d.wr_data", i), we_d, e_wd);
            end
        end

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        check("mem_sweep", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
